// File: rtl/axi_pkg.sv
// Shared AXI encodings and read-slave FSM states, common to the read and write slaves.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } rd_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] start_i,
    input  logic [2:0]        size_i,
    input  logic [3:0]        len_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_o
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wmask;
    logic [ADDR_W-1:0] sum;

    always_comb begin
        step  = ADDR_W'(1) << size_i;
        wmask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
        sum   = addr_i + step;
        case (burst_i)
            BURST_FIXED: next_o = addr_i;
            // Window base comes from the start address, so unaligned WRAP starts still land in-window.
            BURST_WRAP:  next_o = (start_i & ~wmask) | (sum & wmask);
            default:     next_o = sum;
        endcase
    end

endmodule

// File: rtl/axi_read_slave.sv
// AXI3 read responder: one burst at a time, one memory read per beat, 3 cycles per beat.
module axi_read_slave
    import axi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic [1:0]        ARLOCK,
    input  logic [3:0]        ARCACHE,
    input  logic [2:0]        ARPROT,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int SIZE_MAX = $clog2(DATA_W / 8);

    rd_state_e         state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q, start_q, next_addr, rd_addr_q;
    logic [3:0]        len_q, beat_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q, ar_err, rlast_q, rvalid_q, rd_en_q;
    logic              unused_ar_attr;

    assign unused_ar_attr = ^{ARLOCK, ARCACHE, ARPROT};

    assign ar_err = (ARSIZE > 3'(SIZE_MAX)) || (ARBURST == 2'b11)
                  || ((ARBURST == BURST_WRAP) && !wrap_len_ok(ARLEN));

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_next_addr (
        .addr_i  (addr_q),
        .start_i (start_q),
        .size_i  (size_q),
        .len_i   (len_q),
        .burst_i (burst_q),
        .next_o  (next_addr)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (ARVALID) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    if (RREADY) state_d = rlast_q ? ST_IDLE : ST_FETCH;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ARREADY = (state_q == ST_IDLE);
    end

    // The read strobe and address are registered on entry to FETCH so they are high for that cycle only.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q      <= '0;
            addr_q    <= '0;
            start_q   <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (ARVALID) begin
                    id_q      <= ARID;
                    addr_q    <= ARADDR;
                    start_q   <= ARADDR;
                    len_q     <= ARLEN;
                    size_q    <= ARSIZE;
                    burst_q   <= ARBURST;
                    beat_q    <= '0;
                    err_q     <= ar_err;
                    rd_en_q   <= !ar_err;
                    rd_addr_q <= ARADDR;
                end
                ST_CAPTURE: begin
                    rdata_q  <= err_q ? '0 : mem_rd_data;
                    rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
                    rlast_q  <= (beat_q == len_q);
                    rvalid_q <= 1'b1;
                end
                ST_RESP: if (RREADY) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    if (!rlast_q) begin
                        beat_q    <= beat_q + 4'd1;
                        addr_q    <= next_addr;
                        rd_en_q   <= !err_q;
                        rd_addr_q <= next_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RID         = id_q;
    assign RDATA       = rdata_q;
    assign RRESP       = rresp_q;
    assign RLAST       = rlast_q;
    assign RVALID      = rvalid_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// Bench for axi_read_slave: directed table, backpressure/reset sequences, randomized bursts vs a reference model.
module tb_axi_read_slave;

    localparam int DW = 32, AW = 32, IW = 4;

    logic          ACLK = 1'b0, ARESETn = 1'b0;
    logic [IW-1:0] ARID = '0;
    logic [AW-1:0] ARADDR = '0;
    logic [3:0]    ARLEN = '0, ARCACHE = '0;
    logic [2:0]    ARSIZE = '0, ARPROT = '0;
    logic [1:0]    ARBURST = '0, ARLOCK = '0;
    logic          ARVALID = 1'b0, ARREADY;
    logic [IW-1:0] RID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST, RVALID, RREADY = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;

    always #5 ACLK = ~ACLK;

    axi_read_slave #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
        .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA),
        .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: data valid only in the cycle after the strobe, garbage otherwise.
    always @(posedge ACLK) mem_rd_data <= mem_rd_en ? mem_fn(mem_rd_addr) : 32'hBAD0_0BAD;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       rq[$], exp_b[$];
    logic [31:0] aq[$], exp_a[$];

    always @(posedge ACLK) if (ARESETn) begin
        if (RVALID && RREADY) rq.push_back({RID, RDATA, RRESP, RLAST});
        if (mem_rd_en) aq.push_back(mem_rd_addr);
    end

    // A stalled R beat must stay valid and unchanged until accepted.
    bit    pend;
    beat_t pv;
    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) pend = 1'b0;
        else begin
            if (pend) check("r_hold", {RVALID, RID, RDATA, RRESP, RLAST}, {1'b1, pv});
            pend = RVALID && !RREADY;
            pv   = {RID, RDATA, RRESP, RLAST};
        end
    end

    task automatic model(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step, mask, base, a;
        bit err;
        exp_b.delete();
        exp_a.delete();
        step = 32'd1 << size;
        mask = ((32'(len) + 32'd1) << size) - 32'd1;
        base = addr & ~mask;
        err  = (size > 3'd2) || (burst == 2'b11) || (burst == 2'b10 && !(len inside {1, 3, 7, 15}));
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                2'b00:   a = addr;
                2'b10:   a = base | ((addr + 32'(i) * step) & mask);
                default: a = addr + 32'(i) * step;
            endcase
            if (!err) exp_a.push_back(a);
            exp_b.push_back({id, (err ? 32'h0 : mem_fn(a)), (err ? 2'b10 : 2'b00), (i == int'(len))});
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input string nm);
        bit ok = 0;
        @(negedge ACLK);
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARLOCK = 2'($urandom); ARCACHE = 4'($urandom); ARPROT = 3'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(posedge ACLK);
            if (ARREADY) begin ok = 1; break; end
        end
        check({nm, "/ar_handshake"}, 64'(ok), 64'd1);
        #1 ARVALID = 1'b0;
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int rr_pct,
                             input bit junk, input int stall_beat, input string nm);
        int n, arhi = 0;
        bit stalled = 0;
        model(id, addr, len, size, burst);
        rq.delete();
        aq.delete();
        RREADY = ($urandom_range(99) < rr_pct);
        send_ar(id, addr, len, size, burst, nm);
        // A competing request held during the burst must not be taken.
        if (junk) begin
            ARVALID = 1'b1; ARID = ~id; ARADDR = $urandom; ARLEN = 4'($urandom);
        end
        @(negedge ACLK) check({nm, "/lat_fetch"}, 64'(RVALID), 64'd0);
        @(negedge ACLK) check({nm, "/lat_capture"}, 64'(RVALID), 64'd0);
        @(negedge ACLK) check({nm, "/lat_first_rvalid"}, 64'(RVALID), 64'd1);
        for (n = 0; n < 600; n++) begin
            if (rq.size() == int'(len) + 1) break;
            if (ARREADY) arhi++;
            if (stall_beat >= 0 && !stalled && rq.size() == stall_beat && RVALID) begin
                stalled = 1;
                RREADY  = 1'b0;
                repeat (5) begin
                    @(negedge ACLK);
                    check({nm, "/stall_r"}, {RVALID, RDATA, RLAST},
                          {1'b1, exp_b[stall_beat].data, exp_b[stall_beat].last});
                    check({nm, "/stall_reads"}, aq.size(), (exp_a.size() == 0) ? 0 : stall_beat + 1);
                end
            end
            RREADY = ($urandom_range(99) < rr_pct);
            @(negedge ACLK);
        end
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        check({nm, "/done_in_budget"}, 64'(n < 600), 64'd1);
        check({nm, "/arready_low_busy"}, arhi, 0);
        repeat (4) @(negedge ACLK);
        check({nm, "/nbeats"}, rq.size(), int'(len) + 1);
        for (int i = 0; i < rq.size() && i < exp_b.size(); i++) check({nm, "/beat"}, rq[i], exp_b[i]);
        check({nm, "/nreads"}, aq.size(), exp_a.size());
        for (int i = 0; i < aq.size() && i < exp_a.size(); i++) check({nm, "/rd_addr"}, aq[i], exp_a[i]);
    endtask

    typedef struct {
        logic [3:0]        id;
        logic [31:0]       addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        bit                junk;
        logic [1:0]        x_resp;
        int                x_nrd;
        logic [0:3][31:0]  x_a;
        bit                chk_d0;
        logic [31:0]       x_d0;
    } vec_t;

    vec_t vt[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          b;

        vt[0] = '{4'd3, 32'h100, 4'd0, 3'd2, 2'b01, 1'b0, 2'b00, 1, {32'h100, 32'h0, 32'h0, 32'h0}, 1'b1, 32'hDEADBEEF};
        vt[1] = '{4'd1, 32'h200, 4'd3, 3'd2, 2'b01, 1'b1, 2'b00, 4, {32'h200, 32'h204, 32'h208, 32'h20C}, 1'b0, 32'h0};
        vt[2] = '{4'd2, 32'h01C, 4'd3, 3'd2, 2'b10, 1'b0, 2'b00, 4, {32'h01C, 32'h010, 32'h014, 32'h018}, 1'b0, 32'h0};
        vt[3] = '{4'd4, 32'h300, 4'd1, 3'd3, 2'b01, 1'b0, 2'b10, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 32'h0};
        vt[4] = '{4'd6, 32'h400, 4'd2, 3'd2, 2'b11, 1'b1, 2'b10, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 32'h0};
        vt[5] = '{4'd7, 32'h040, 4'd2, 3'd2, 2'b10, 1'b0, 2'b10, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 32'h0};
        vt[6] = '{4'd8, 32'h500, 4'd3, 3'd2, 2'b00, 1'b0, 2'b00, 4, {32'h500, 32'h500, 32'h500, 32'h500}, 1'b0, 32'h0};
        vt[7] = '{4'd9, 32'h203, 4'd2, 3'd1, 2'b01, 1'b0, 2'b00, 3, {32'h203, 32'h205, 32'h207, 32'h0}, 1'b0, 32'h0};

        #12;
        check("rst_arready", 64'(ARREADY), 64'd1);
        check("rst_ctrl", {RVALID, RLAST, mem_rd_en}, 64'd0);
        check("rst_data", {RID, RRESP, RDATA}, 64'd0);
        check("rst_rd_addr", mem_rd_addr, 64'd0);
        @(negedge ACLK) ARESETn = 1'b1;

        foreach (vt[i]) begin
            run_burst(vt[i].id, vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, 100, vt[i].junk, -1,
                      $sformatf("vec%0d", i));
            check($sformatf("vec%0d/tbl_nreads", i), aq.size(), vt[i].x_nrd);
            for (int k = 0; k < vt[i].x_nrd && k < 4 && k < aq.size(); k++)
                check($sformatf("vec%0d/tbl_addr%0d", i, k), aq[k], vt[i].x_a[k]);
            if (rq.size() > 0) begin
                check($sformatf("vec%0d/tbl_resp", i), rq[0].resp, vt[i].x_resp);
                check($sformatf("vec%0d/tbl_rid", i), rq[0].id, vt[i].id);
                if (vt[i].chk_d0) check($sformatf("vec%0d/tbl_data", i), rq[0].data, vt[i].x_d0);
            end
        end

        run_burst(4'd11, 32'h600, 4'd2, 3'd2, 2'b01, 100, 1'b0, 1, "backpressure");

        // Reset asserted while beat 2 of 4 is on the bus.
        begin
            bit reached = 0;
            model(4'd10, 32'h700, 4'd3, 3'd2, 2'b01);
            rq.delete();
            RREADY = 1'b1;
            send_ar(4'd10, 32'h700, 4'd3, 3'd2, 2'b01, "midrst");
            for (int i = 0; i < 50; i++) begin
                @(negedge ACLK);
                if (rq.size() == 1 && RVALID) begin reached = 1; break; end
            end
            check("midrst/reached_beat2", 64'(reached), 64'd1);
            #2 ARESETn = 1'b0;
            #1;
            check("midrst/rvalid_async", {RVALID, RLAST, mem_rd_en}, 64'd0);
            check("midrst/arready", 64'(ARREADY), 64'd1);
            @(negedge ACLK) ARESETn = 1'b1;
            repeat (10) @(negedge ACLK);
            check("midrst/no_more_beats", rq.size(), 1);
            check("midrst/idle_after", 64'(ARREADY), 64'd1);
            run_burst(4'd5, 32'h800, 4'd3, 3'd2, 2'b01, 100, 1'b0, -1, "after_rst");
        end

        for (int t = 0; t < 40; t++) begin
            size = ($urandom_range(7) == 0) ? 3'd3 : 3'($urandom_range(2));
            b = $urandom_range(7);
            burst = (b == 7) ? 2'b11 : 2'(b % 3);
            len = 4'($urandom);
            if (burst == 2'b10 && $urandom_range(1) == 1) len = (4'd1 << $urandom_range(1, 4)) - 4'd1;
            run_burst(4'($urandom), $urandom, len, size, burst, $urandom_range(50, 100),
                      1'($urandom), -1, $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
